vga_frame_swap_ctrl: RTL and testbench

Double-buffer page-flip controller in the `clk_vga` domain, directly upstream of the VGA scan-out stage. The renderer finishes a frame in the back buffer and signals this with a toggle from the `clk` domain. This block synchronises that request and defers the swap to the next vertical-sync falling edge, so scan-out never tears. It then drives the front-buffer select and returns a toggle acknowledge.

---
 rtl/vga_pkg.sv | 15 +
 rtl/toggle_sync.sv | 27 ++
 rtl/vga_frame_swap_ctrl.sv | 91 +++++++++
 tb/tb_vga_frame_swap_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the page-flip FSM state type.
package vga_pkg;

  localparam int H_LINE_PERIOD  = 1056;
  localparam int V_FRAME_PERIOD = 628;
  // Two whole frames without a vsync edge means scan-out timing is gone.
  localparam int VS_TIMEOUT_DEF = 2 * H_LINE_PERIOD * V_FRAME_PERIOD;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_FLIP    = 2'd2
  } swap_state_t;

endpackage

// File: rtl/toggle_sync.sv
// Toggle-to-event synchroniser: STAGES flops plus a history flop; one-cycle
// o_evt per input toggle. Reusable on either side of a toggle handshake.
module toggle_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_tgl,
  output logic o_evt
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_tgl};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign o_evt = r_sync[STAGES-1] ^ r_hist;

endmodule

// File: rtl/vga_frame_swap_ctrl.sv
// Double-buffer page-flip controller: a synchronised renderer request is
// held until the next vsync falling edge, then the front buffer is swapped.
module vga_frame_swap_ctrl
  import vga_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_CNT_W = 16,
  parameter int VS_TIMEOUT  = VS_TIMEOUT_DEF
) (
  input  logic                   clk_vga,
  input  logic                   reset_n,
  input  logic                   i_vs,
  input  logic                   i_flip_req_tgl,
  output logic                   o_front_buf,
  output logic                   o_flip_ack_tgl,
  output logic                   o_pending,
  output logic                   o_overrun,
  output logic                   o_vs_lost,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt,
  output swap_state_t            o_dbg_state
);

  localparam int               GAP_W   = $clog2(VS_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(VS_TIMEOUT);

  swap_state_t            r_state;
  swap_state_t            w_next;
  logic                   w_req_evt;
  logic                   w_vs_fall;
  logic                   r_vs_d;
  logic                   r_front_buf;
  logic                   r_flip_ack_tgl;
  logic                   r_overrun;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic [GAP_W-1:0]       r_gap;

  toggle_sync #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk    (clk_vga),
    .reset_n(reset_n),
    .i_tgl  (i_flip_req_tgl),
    .o_evt  (w_req_evt)
  );

  // i_vs is active-low, so the falling edge marks the start of a frame.
  assign w_vs_fall = r_vs_d & ~i_vs;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_req_evt) w_next = ST_PENDING;
      ST_PENDING: if (w_vs_fall) w_next = ST_FLIP;
      ST_FLIP:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_vs_d         <= 1'b1;
      r_front_buf    <= 1'b0;
      r_flip_ack_tgl <= 1'b0;
      r_overrun      <= 1'b0;
      r_frame_cnt    <= '0;
      r_gap          <= '0;
    end else begin
      r_state <= w_next;
      r_vs_d  <= i_vs;
      if (r_state == ST_FLIP) begin
        r_front_buf    <= ~r_front_buf;
        r_flip_ack_tgl <= ~r_flip_ack_tgl;
      end
      // A request while one is outstanding is dropped and flagged sticky.
      if (w_req_evt && (r_state != ST_IDLE)) r_overrun <= 1'b1;
      if (w_vs_fall) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_vs_fall)            r_gap <= '0;
      else if (r_gap != GAP_MAX) r_gap <= r_gap + 1'b1;
    end
  end

  assign o_front_buf    = r_front_buf;
  assign o_flip_ack_tgl = r_flip_ack_tgl;
  assign o_pending      = (r_state != ST_IDLE);
  assign o_overrun      = r_overrun;
  assign o_vs_lost      = (r_gap == GAP_MAX);
  assign o_frame_cnt    = r_frame_cnt;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_vga_frame_swap_ctrl.sv
// Bench for vga_frame_swap_ctrl: scenario tasks plus an ack-driven scoreboard.
module tb_vga_frame_swap_ctrl;
  import vga_pkg::*;

  localparam int TB_CNT_W      = 4;
  localparam int TB_VS_TIMEOUT = 200;

  logic                clk_vga;
  logic                reset_n;
  logic                i_vs;
  logic                i_flip_req_tgl;
  logic                o_front_buf;
  logic                o_flip_ack_tgl;
  logic                o_pending;
  logic                o_overrun;
  logic                o_vs_lost;
  logic [TB_CNT_W-1:0] o_frame_cnt;
  swap_state_t         o_dbg_state;

  int total = 0;
  int bad   = 0;

  // Scoreboard entries are {front_buf, flip_ack_tgl} expected after a flip.
  logic [1:0]          exp_q[$];
  logic                m_front;
  logic                m_ack;
  logic [TB_CNT_W-1:0] exp_cnt;
  logic                prev_ack;

  vga_frame_swap_ctrl #(
    .SYNC_STAGES(2),
    .FRAME_CNT_W(TB_CNT_W),
    .VS_TIMEOUT (TB_VS_TIMEOUT)
  ) dut (
    .clk_vga       (clk_vga),
    .reset_n       (reset_n),
    .i_vs          (i_vs),
    .i_flip_req_tgl(i_flip_req_tgl),
    .o_front_buf   (o_front_buf),
    .o_flip_ack_tgl(o_flip_ack_tgl),
    .o_pending     (o_pending),
    .o_overrun     (o_overrun),
    .o_vs_lost     (o_vs_lost),
    .o_frame_cnt   (o_frame_cnt),
    .o_dbg_state   (o_dbg_state)
  );

  // Clock and reset
  initial begin
    clk_vga = 1'b0;
    forever #5 clk_vga = ~clk_vga;
  end

  // Scoreboard: every ack toggle must match the oldest expected flip.
  initial prev_ack = 1'b0;
  always @(negedge clk_vga) begin
    if (!reset_n) begin
      prev_ack = o_flip_ack_tgl;
    end else if (o_flip_ack_tgl !== prev_ack) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_flip: front=%0b ack=%0b, no flip expected",
                 o_front_buf, o_flip_ack_tgl);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if ({o_front_buf, o_flip_ack_tgl} !== e) begin
          bad++;
          $display("FAIL sb_flip: got {front,ack}=%b expected %b",
                   {o_front_buf, o_flip_ack_tgl}, e);
        end
      end
      prev_ack = o_flip_ack_tgl;
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk_vga);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    i_vs           = 1'b1;
    i_flip_req_tgl = 1'b0;
    m_front        = 1'b0;
    m_ack          = 1'b0;
    exp_cnt        = '0;
    tick(3);
    reset_n = 1'b1;
  endtask

  task automatic toggle_req();
    i_flip_req_tgl = ~i_flip_req_tgl;
  endtask

  task automatic expect_flip();
    m_front = ~m_front;
    m_ack   = ~m_ack;
    exp_q.push_back({m_front, m_ack});
  endtask

  task automatic vs_low();
    i_vs    = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic vsync_no_req();
    vs_low();
    tick(3);
    i_vs = 1'b1;
    tick(3);
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    total++;
    if ({o_front_buf, o_flip_ack_tgl, o_pending, o_overrun, o_vs_lost} !== 5'b0 ||
        o_frame_cnt !== '0 || o_dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_vals: front=%0b ack=%0b pend=%0b ovr=%0b lost=%0b cnt=%0d st=%0d, expected all 0 / IDLE",
               o_front_buf, o_flip_ack_tgl, o_pending, o_overrun, o_vs_lost, o_frame_cnt, o_dbg_state);
    end
  endtask

  task automatic test_basic_flip();
    tick(10);
    toggle_req();
    tick(2);
    total++;
    if (o_pending !== 1'b0) begin
      bad++;
      $display("FAIL basic_early_pend: pending=%0b expected 0", o_pending);
    end
    tick(2);
    total++;
    if (o_pending !== 1'b1 || o_dbg_state !== ST_PENDING) begin
      bad++;
      $display("FAIL basic_pend: pending=%0b st=%0d expected 1/PENDING", o_pending, o_dbg_state);
    end
    tick(86);
    vs_low();
    expect_flip();
    tick(1);
    total++;
    if (o_front_buf !== 1'b0 || o_dbg_state !== ST_FLIP || o_frame_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL basic_flip_state: front=%0b st=%0d cnt=%0d expected 0/FLIP/%0d",
               o_front_buf, o_dbg_state, o_frame_cnt, exp_cnt);
    end
    tick(1);
    total++;
    if (o_front_buf !== 1'b1 || o_flip_ack_tgl !== 1'b1 || o_pending !== 1'b0) begin
      bad++;
      $display("FAIL basic_done: front=%0b ack=%0b pend=%0b expected 1/1/0",
               o_front_buf, o_flip_ack_tgl, o_pending);
    end
    i_vs = 1'b1;
    tick(3);
  endtask

  task automatic test_coincident();
    toggle_req();
    tick(2);
    vs_low();
    tick(1);
    total++;
    if (o_dbg_state !== ST_PENDING || o_frame_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL coinc_pend: st=%0d cnt=%0d expected PENDING/%0d", o_dbg_state, o_frame_cnt, exp_cnt);
    end
    tick(1);
    total++;
    if (o_front_buf !== m_front || o_pending !== 1'b1) begin
      bad++;
      $display("FAIL coinc_no_flip: front=%0b pend=%0b expected %0b/1", o_front_buf, o_pending, m_front);
    end
    i_vs = 1'b1;
    tick(5);
    vs_low();
    expect_flip();
    tick(2);
    total++;
    if (o_front_buf !== m_front || o_pending !== 1'b0 || o_frame_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL coinc_flip: front=%0b pend=%0b cnt=%0d expected %0b/0/%0d",
               o_front_buf, o_pending, o_frame_cnt, m_front, exp_cnt);
    end
    i_vs = 1'b1;
    tick(3);
  endtask

  task automatic test_overrun();
    toggle_req();
    tick(4);
    total++;
    if (o_pending !== 1'b1 || o_overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_pre: pend=%0b ovr=%0b expected 1/0", o_pending, o_overrun);
    end
    toggle_req();
    tick(4);
    total++;
    if (o_overrun !== 1'b1 || o_dbg_state !== ST_PENDING) begin
      bad++;
      $display("FAIL ovr_set: ovr=%0b st=%0d expected 1/PENDING", o_overrun, o_dbg_state);
    end
    vs_low();
    expect_flip();
    tick(3);
    i_vs = 1'b1;
    tick(3);
    vsync_no_req();
    total++;
    if (o_front_buf !== m_front || o_flip_ack_tgl !== m_ack || o_overrun !== 1'b1 || o_pending !== 1'b0) begin
      bad++;
      $display("FAIL ovr_single_flip: front=%0b ack=%0b ovr=%0b pend=%0b expected %0b/%0b/1/0",
               o_front_buf, o_flip_ack_tgl, o_overrun, o_pending, m_front, m_ack);
    end
  endtask

  task automatic test_vs_lost();
    toggle_req();
    tick(4);
    tick(TB_VS_TIMEOUT + 5);
    total++;
    if (o_vs_lost !== 1'b1 || o_dbg_state !== ST_PENDING) begin
      bad++;
      $display("FAIL vslost_set: lost=%0b st=%0d expected 1/PENDING", o_vs_lost, o_dbg_state);
    end
    vs_low();
    expect_flip();
    tick(1);
    total++;
    if (o_vs_lost !== 1'b0) begin
      bad++;
      $display("FAIL vslost_clear: lost=%0b expected 0", o_vs_lost);
    end
    tick(1);
    total++;
    if (o_front_buf !== m_front || o_pending !== 1'b0) begin
      bad++;
      $display("FAIL vslost_flip: front=%0b pend=%0b expected %0b/0", o_front_buf, o_pending, m_front);
    end
    i_vs = 1'b1;
    tick(3);
  endtask

  task automatic test_frame_wrap();
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      vsync_no_req();
      if (i >= 15) begin
        total++;
        if (o_frame_cnt !== exp_cnt) begin
          bad++;
          $display("FAIL wrap_cnt_%0d: cnt=%0d expected %0d", i, o_frame_cnt, exp_cnt);
        end
      end
    end
  endtask

  task automatic test_reset_mid_pending();
    toggle_req();
    tick(4);
    vs_low();
    expect_flip();
    tick(3);
    i_vs = 1'b1;
    tick(2);
    toggle_req();
    tick(4);
    toggle_req();
    tick(4);
    total++;
    if (o_pending !== 1'b1 || o_overrun !== 1'b1 || o_front_buf !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre: pend=%0b ovr=%0b front=%0b expected 1/1/1", o_pending, o_overrun, o_front_buf);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({o_front_buf, o_flip_ack_tgl, o_pending, o_overrun, o_vs_lost} !== 5'b0 ||
        o_frame_cnt !== '0 || o_dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL rstmid_async: front=%0b ack=%0b pend=%0b ovr=%0b lost=%0b cnt=%0d st=%0d expected 0 / IDLE",
               o_front_buf, o_flip_ack_tgl, o_pending, o_overrun, o_vs_lost, o_frame_cnt, o_dbg_state);
    end
    i_flip_req_tgl = 1'b0;
    m_front = 1'b0;
    m_ack   = 1'b0;
    exp_cnt = '0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    vsync_no_req();
    total++;
    if (o_front_buf !== 1'b0 || o_flip_ack_tgl !== 1'b0 || o_pending !== 1'b0 || o_frame_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL rstmid_no_flip: front=%0b ack=%0b pend=%0b cnt=%0d expected 0/0/0/%0d",
               o_front_buf, o_flip_ack_tgl, o_pending, o_frame_cnt, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_flip();
    test_coincident();
    test_overrun();
    test_vs_lost();
    test_frame_wrap();
    test_reset_mid_pending();
    tick(5);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d flips outstanding, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
